// File: rtl/axi_burst_wr_master.sv
`default_nettype none
// axi_burst_wr_master: one-outstanding AXI4 INCR write-burst master with a pass-through W channel.
// Optional macro AXI_WR_MASTER_4K_CHECK_EN rejects commands whose burst would cross a 4KB boundary.
module axi_burst_wr_master #(
  parameter int         ADDR_WIDTH = 16,
  parameter int         DATA_WIDTH = 32,
  parameter logic [3:0] AXI_ID     = 4'hA
) (
  input  logic                    axi_ACLK,
  input  logic                    axi_ARESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  output logic                    done,
  output logic [1:0]              done_resp,
  output logic                    axi_AWVALID,
  input  logic                    axi_AWREADY,
  output logic [3:0]              axi_AWID,
  output logic [ADDR_WIDTH-1:0]   axi_AWADDR,
  output logic [7:0]              axi_AWLEN,
  output logic [2:0]              axi_AWSIZE,
  output logic [1:0]              axi_AWBURST,
  output logic                    axi_WVALID,
  input  logic                    axi_WREADY,
  output logic [DATA_WIDTH-1:0]   axi_WDATA,
  output logic [DATA_WIDTH/8-1:0] axi_WSTRB,
  output logic                    axi_WLAST,
  input  logic                    axi_BVALID,
  output logic                    axi_BREADY,
  input  logic [3:0]              axi_BID,
  input  logic [1:0]              axi_BRESP
);

  localparam int         STROBE_WIDTH = DATA_WIDTH / 8;
  localparam logic [2:0] SIZE_ENC     = 3'($clog2(STROBE_WIDTH));
  localparam logic [1:0] RESP_SLVERR  = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    DATA   = 3'd2,
    RESP   = 3'd3,
    REJECT = 3'd4
  } state_t;

  state_t                  state;
  state_t                  state_nx;
  logic                    live;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              len_q;
  logic [7:0]              beat_cnt;
  logic [3:0]              id_q;
  logic                    done_q;
  logic [1:0]              resp_q;
  logic                    cmd_accept;
  logic                    w_hs;
  logic                    crosses_4k;

`ifdef AXI_WR_MASTER_4K_CHECK_EN
  logic [20:0] burst_end;
  assign burst_end  = 21'(cmd_addr[11:0]) + ((21'(cmd_len) + 21'd1) << $clog2(STROBE_WIDTH));
  assign crosses_4k = burst_end > 21'd4096;
`else
  assign crosses_4k = 1'b0;
`endif

  assign cmd_accept  = cmd_valid && cmd_ready;
  assign w_hs        = (state == DATA) && s_wvalid && axi_WREADY;

  assign axi_AWADDR  = addr_q;
  assign axi_AWLEN   = len_q;
  assign axi_AWID    = id_q;
  assign axi_AWSIZE  = SIZE_ENC;
  assign axi_AWBURST = 2'b01;
  assign done        = done_q;
  assign done_resp   = resp_q;

  always_ff @(posedge axi_ACLK or posedge axi_ARESET) begin
    if (axi_ARESET) state <= IDLE;
    else            state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    cmd_ready   = 1'b0;
    axi_AWVALID = 1'b0;
    axi_WVALID  = 1'b0;
    s_wready    = 1'b0;
    axi_WDATA   = '0;
    axi_WSTRB   = '0;
    axi_WLAST   = 1'b0;
    axi_BREADY  = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = live;
        if (cmd_valid && live) state_nx = crosses_4k ? REJECT : ADDR;
      end
      ADDR: begin
        axi_AWVALID = 1'b1;
        if (axi_AWREADY) state_nx = DATA;
      end
      DATA: begin
        axi_WVALID = s_wvalid;
        s_wready   = axi_WREADY;
        axi_WDATA  = s_wdata;
        axi_WSTRB  = '1;
        axi_WLAST  = (beat_cnt == 8'd0);
        if (s_wvalid && axi_WREADY && beat_cnt == 8'd0) state_nx = RESP;
      end
      RESP: begin
        axi_BREADY = 1'b1;
        if (axi_BVALID) state_nx = IDLE;
      end
      REJECT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // live keeps cmd_ready low until the first edge after reset release
  always_ff @(posedge axi_ACLK or posedge axi_ARESET) begin
    if (axi_ARESET) begin
      live     <= 1'b0;
      addr_q   <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
      id_q     <= '0;
      done_q   <= 1'b0;
      resp_q   <= '0;
    end else begin
      live   <= 1'b1;
      done_q <= 1'b0;
      if (cmd_accept) begin
        addr_q   <= cmd_addr;
        len_q    <= cmd_len;
        beat_cnt <= cmd_len;
        id_q     <= AXI_ID;
      end
      if (w_hs && beat_cnt != 8'd0) beat_cnt <= beat_cnt - 8'd1;
      if (state == RESP && axi_BVALID) begin
        done_q <= 1'b1;
        resp_q <= (axi_BID == AXI_ID) ? axi_BRESP : RESP_SLVERR;
      end
      if (state == REJECT) begin
        done_q <= 1'b1;
        resp_q <= RESP_SLVERR;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_burst_wr_master.sv
`default_nettype none
// Bench for axi_burst_wr_master: scripted AXI slave and upstream source with AW/W/done scoreboards.
module tb_axi_burst_wr_master;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        s_wvalid;
  logic        s_wready;
  logic [31:0] s_wdata;
  logic        done;
  logic [1:0]  done_resp;
  logic        awvalid;
  logic        awready;
  logic [3:0]  awid;
  logic [15:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid;
  logic        bready;
  logic [3:0]  bid;
  logic [1:0]  bresp;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } wexp_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  len;
  } awexp_t;

  wexp_t      wq[$];
  awexp_t     awq[$];
  logic [1:0] rq[$];

  int total = 0;
  int bad   = 0;
  int aw_cycles;
  int w_beats;

  wexp_t      mon_w;
  awexp_t     mon_aw;
  logic [1:0] mon_r;

  axi_burst_wr_master #(
    .ADDR_WIDTH(16),
    .DATA_WIDTH(32),
    .AXI_ID    (4'hA)
  ) dut (
    .axi_ACLK   (clk),
    .axi_ARESET (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .s_wvalid   (s_wvalid),
    .s_wready   (s_wready),
    .s_wdata    (s_wdata),
    .done       (done),
    .done_resp  (done_resp),
    .axi_AWVALID(awvalid),
    .axi_AWREADY(awready),
    .axi_AWID   (awid),
    .axi_AWADDR (awaddr),
    .axi_AWLEN  (awlen),
    .axi_AWSIZE (awsize),
    .axi_AWBURST(awburst),
    .axi_WVALID (wvalid),
    .axi_WREADY (wready),
    .axi_WDATA  (wdata),
    .axi_WSTRB  (wstrb),
    .axi_WLAST  (wlast),
    .axi_BVALID (bvalid),
    .axi_BREADY (bready),
    .axi_BID    (bid),
    .axi_BRESP  (bresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change at posedge+1, so at negedge they show the handshakes of the coming edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (awvalid) begin
        aw_cycles++;
        total++;
        if (awq.size() == 0) begin
          bad++;
          $display("FAIL aw_unexpected: AWVALID=1 addr=%h len=%0d, required no AW", awaddr, awlen);
        end else begin
          mon_aw = awq[0];
          if ({awaddr, awlen, awid, awsize, awburst} !== {mon_aw.addr, mon_aw.len, 4'hA, 3'd2, 2'b01}) begin
            bad++;
            $display("FAIL aw_fields: got addr=%h len=%0d id=%h size=%0d burst=%b, required addr=%h len=%0d id=a size=2 burst=01",
                     awaddr, awlen, awid, awsize, awburst, mon_aw.addr, mon_aw.len);
          end
          if (awready) awq.delete(0);
        end
        total++;
        if (wvalid !== 1'b0) begin
          bad++;
          $display("FAIL w_before_aw: WVALID=%b during AW phase, required 0", wvalid);
        end
      end
      if (wvalid && wready) begin
        w_beats++;
        total++;
        if (wq.size() == 0) begin
          bad++;
          $display("FAIL w_unexpected: W beat data=%h, required none", wdata);
        end else begin
          mon_w = wq.pop_front();
          if ({wdata, wlast, wstrb} !== {mon_w.data, mon_w.last, 4'hF}) begin
            bad++;
            $display("FAIL w_beat: got data=%h last=%b strb=%h, required data=%h last=%b strb=f",
                     wdata, wlast, wstrb, mon_w.data, mon_w.last);
          end
        end
      end
      if (done) begin
        total++;
        if (rq.size() == 0) begin
          bad++;
          $display("FAIL done_unexpected: done=1 resp=%b, required no done", done_resp);
        end else begin
          mon_r = rq.pop_front();
          if (done_resp !== mon_r) begin
            bad++;
            $display("FAIL done_resp: got %b, required %b", done_resp, mon_r);
          end
        end
      end
    end
  end

  // Runs one command against the scripted slave; BVALID is offered from the start so
  // that an early response is exercised. lat = done cycle minus accept cycle.
  task automatic drive_burst(input logic [15:0] addr, input int len, input int aw_stall,
                             input bit w_alt, input bit s_gaps, input logic [1:0] rsp,
                             input logic [3:0] id, input int abort_beat, output int lat);
    int    beat, stall, acc_i;
    bit    hs_cmd, hs_w, hs_b, phase, fin;
    wexp_t e;
    beat = 0; stall = 0; acc_i = 0; phase = 1'b1; fin = 1'b0; lat = -1;
    aw_cycles = 0; w_beats = 0;
    cmd_addr = addr; cmd_len = 8'(len); cmd_valid = 1'b1;
    bresp = rsp; bid = id; bvalid = 1'b1;
    for (int i = 0; i < 3000 && !fin; i++) begin
      awready = awvalid ? (stall >= aw_stall) : 1'b1;
      if (awvalid && stall < aw_stall) stall++;
      wready   = w_alt ? phase : 1'b1;
      phase    = ~phase;
      s_wvalid = (beat <= len) && !(s_gaps && (i % 3 == 1));
      s_wdata  = 32'hD000_0000 + (32'(addr) << 8) + 32'(beat);
      #1;
      hs_cmd = cmd_valid && cmd_ready;
      hs_w   = s_wvalid && s_wready;
      hs_b   = bvalid && bready;
      if (hs_cmd) acc_i = i;
      if (hs_w) begin
        e.data = s_wdata;
        e.last = (beat == len);
        wq.push_back(e);
      end
      @(posedge clk); #1;
      if (hs_cmd) cmd_valid = 1'b0;
      if (hs_w)   beat++;
      if (hs_b)   bvalid = 1'b0;
      if (done) begin
        fin = 1'b1;
        lat = i + 1 - acc_i;
      end else if (abort_beat >= 0 && beat == abort_beat) begin
        return;
      end
    end
    s_wvalid = 1'b0; bvalid = 1'b0; awready = 1'b0; wready = 1'b0;
    if (!fin) begin
      total++; bad++;
      $display("FAIL burst_timeout: done=0 after 3000 cycles, required done=1");
    end
  endtask

  task automatic push_normal(input logic [15:0] addr, input int len, input logic [1:0] r);
    awexp_t a;
    a.addr = addr;
    a.len  = 8'(len);
    awq.push_back(a);
    rq.push_back(r);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({cmd_ready, awvalid, wvalid, wlast, bready, done, s_wready} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctrl: cmd_ready/awvalid/wvalid/wlast/bready/done/s_wready=%b, required 0000000",
               {cmd_ready, awvalid, wvalid, wlast, bready, done, s_wready});
    end
    total++;
    if ({awaddr, awlen, awid, wdata, done_resp} !== 62'd0) begin
      bad++;
      $display("FAIL reset_data: addr=%h len=%h id=%h wdata=%h resp=%b, required all 0",
               awaddr, awlen, awid, wdata, done_resp);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL idle_cmd_ready: got %b, required 1", cmd_ready);
    end
  endtask

  task automatic test_basic();
    int lat;
    push_normal(16'h0000, 7, 2'b00);
    drive_burst(16'h0000, 7, 0, 1'b0, 1'b0, 2'b00, 4'hA, -1, lat);
    total++;
    if (w_beats !== 8 || aw_cycles !== 1) begin
      bad++;
      $display("FAIL basic_counts: beats=%0d aw_cycles=%0d, required 8 and 1", w_beats, aw_cycles);
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || done_resp !== 2'b00 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL done_pulse: done=%b resp=%b cmd_ready=%b, required 0 00 1", done, done_resp, cmd_ready);
    end
  endtask

  task automatic test_aw_stall();
    int lat;
    push_normal(16'h0040, 2, 2'b00);
    drive_burst(16'h0040, 2, 5, 1'b0, 1'b0, 2'b00, 4'hA, -1, lat);
    total++;
    if (aw_cycles !== 6 || w_beats !== 3) begin
      bad++;
      $display("FAIL aw_stall: aw_cycles=%0d beats=%0d, required 6 and 3", aw_cycles, w_beats);
    end
  endtask

  task automatic test_w_gaps();
    int lat;
    push_normal(16'h0200, 3, 2'b00);
    drive_burst(16'h0200, 3, 0, 1'b1, 1'b1, 2'b00, 4'hA, -1, lat);
    total++;
    if (w_beats !== 4) begin
      bad++;
      $display("FAIL w_gaps: beats=%0d, required 4", w_beats);
    end
  endtask

  task automatic test_bresp();
    int lat;
    push_normal(16'h0300, 1, 2'b10);
    drive_burst(16'h0300, 1, 0, 1'b0, 1'b0, 2'b00, 4'h3, -1, lat);
    push_normal(16'h0400, 0, 2'b10);
    drive_burst(16'h0400, 0, 0, 1'b0, 1'b0, 2'b10, 4'hA, -1, lat);
    total++;
    if (w_beats !== 1) begin
      bad++;
      $display("FAIL single_beat: beats=%0d, required 1", w_beats);
    end
    push_normal(16'h0480, 2, 2'b01);
    drive_burst(16'h0480, 2, 0, 1'b0, 1'b0, 2'b01, 4'hA, -1, lat);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (done_resp !== 2'b01) begin
      bad++;
      $display("FAIL resp_hold: got %b, required 01", done_resp);
    end
  endtask

  task automatic test_long();
    int lat;
    push_normal(16'h2000, 255, 2'b00);
    drive_burst(16'h2000, 255, 0, 1'b0, 1'b0, 2'b00, 4'hA, -1, lat);
    total++;
    if (w_beats !== 256) begin
      bad++;
      $display("FAIL long_burst: beats=%0d, required 256", w_beats);
    end
  endtask

  task automatic test_reset_midburst();
    int lat;
    push_normal(16'h0500, 7, 2'b00);
    drive_burst(16'h0500, 7, 0, 1'b0, 1'b0, 2'b00, 4'hA, 3, lat);
    rst = 1'b1;
    #1;
    total++;
    if ({awvalid, wvalid, wlast, bready, done, cmd_ready, s_wready} !== 7'b0) begin
      bad++;
      $display("FAIL abort_ctrl: awvalid/wvalid/wlast/bready/done/cmd_ready/s_wready=%b, required 0000000",
               {awvalid, wvalid, wlast, bready, done, cmd_ready, s_wready});
    end
    total++;
    if ({awaddr, awlen, awid, wdata, done_resp} !== 62'd0 || w_beats !== 3) begin
      bad++;
      $display("FAIL abort_data: addr=%h len=%h id=%h wdata=%h resp=%b beats=%0d, required all 0 and 3 beats",
               awaddr, awlen, awid, wdata, done_resp, w_beats);
    end
    wq.delete(); awq.delete(); rq.delete();
    s_wvalid = 1'b0; bvalid = 1'b0; cmd_valid = 1'b0; awready = 1'b0; wready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    push_normal(16'h0600, 2, 2'b00);
    drive_burst(16'h0600, 2, 0, 1'b0, 1'b0, 2'b00, 4'hA, -1, lat);
    total++;
    if (w_beats !== 3) begin
      bad++;
      $display("FAIL after_abort: beats=%0d, required 3", w_beats);
    end
  endtask

  task automatic test_4k();
    int lat;
    // ends exactly on the boundary: always legal
    push_normal(16'h0FE0, 7, 2'b00);
    drive_burst(16'h0FE0, 7, 0, 1'b0, 1'b0, 2'b00, 4'hA, -1, lat);
    total++;
    if (w_beats !== 8) begin
      bad++;
      $display("FAIL edge_4k: beats=%0d, required 8", w_beats);
    end
`ifdef AXI_WR_MASTER_4K_CHECK_EN
    rq.push_back(2'b10);
    drive_burst(16'h0FF0, 7, 0, 1'b0, 1'b0, 2'b00, 4'hA, -1, lat);
    total++;
    if (aw_cycles !== 0 || w_beats !== 0 || lat !== 2) begin
      bad++;
      $display("FAIL cross_4k: aw_cycles=%0d beats=%0d latency=%0d, required 0 0 2", aw_cycles, w_beats, lat);
    end
`else
    push_normal(16'h0FF0, 7, 2'b00);
    drive_burst(16'h0FF0, 7, 0, 1'b0, 1'b0, 2'b00, 4'hA, -1, lat);
    total++;
    if (aw_cycles !== 1 || w_beats !== 8) begin
      bad++;
      $display("FAIL cross_4k: aw_cycles=%0d beats=%0d, required 1 and 8", aw_cycles, w_beats);
    end
`endif
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    s_wvalid = 1'b0; s_wdata = '0;
    awready = 1'b0; wready = 1'b0;
    bvalid = 1'b0; bid = '0; bresp = '0;
    aw_cycles = 0; w_beats = 0;
    test_reset();
    test_basic();
    test_aw_stall();
    test_w_gaps();
    test_bresp();
    test_reset_midburst();
    test_long();
    test_4k();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (wq.size() != 0 || awq.size() != 0 || rq.size() != 0) begin
      bad++;
      $display("FAIL leftover: w=%0d aw=%0d resp=%0d expectations unconsumed, required 0",
               wq.size(), awq.size(), rq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
